// File: rtl/vip_dehaze_pkg.sv
// ---------------------------------------------------------------------------
// vip_dehaze_pkg
// Shared definitions for the dark-channel dehaze pipeline stages.
//   PIX_W   : pixel width of the dark-channel stream
//   CNT_W   : pixel counter width, large enough for a 2047x2047 frame
//   state_t : frame capture state machine encoding
//   sat8    : clamp a signed 10-bit intermediate into the 0..255 pixel range
// ---------------------------------------------------------------------------
package vip_dehaze_pkg;

   localparam int PIX_W = 8;
   localparam int CNT_W = 22;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Saturate a signed sum back into an unsigned 8-bit pixel value.
   function automatic logic [PIX_W-1:0] sat8(input logic signed [9:0] value);
      logic [PIX_W-1:0] result;
      if (value < 10'sd0) begin
         result = '0;
      end else if (value > 10'sd255) begin
         result = '1;
      end else begin
         result = value[PIX_W-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/vip_frame_sync_edge.sv
// ---------------------------------------------------------------------------
// vip_frame_sync_edge
// Registers the frame vsync and produces single-cycle rise/fall pulses.
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   i_vsync     : frame valid, high for the whole frame
//   o_vsync_d   : i_vsync delayed by one clock (0 in reset)
//   o_rise      : i_vsync is high this clock and was low last clock
//   o_fall      : i_vsync is low this clock and was high last clock
// ---------------------------------------------------------------------------
module vip_frame_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_vsync,
   output logic o_vsync_d,
   output logic o_rise,
   output logic o_fall
);

   logic r_vsync;
   logic r_armed;

   // Delayed copy of vsync. r_armed stays low after reset until vsync has
   // been seen low once, so releasing reset in the middle of a frame does not
   // masquerade as a frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_vsync <= i_vsync;
         if (!i_vsync) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign o_vsync_d = r_vsync;
   assign o_rise    = i_vsync & ~r_vsync & r_armed;
   assign o_fall    = ~i_vsync & r_vsync;

endmodule

// File: rtl/vip_atmos_light_estimate.sv
// ---------------------------------------------------------------------------
// vip_atmos_light_estimate
// Estimates atmospheric light A from the min-filtered dark-channel stream.
// A is the per-frame maximum, clamped below at A_MIN and IIR-smoothed across
// frames; it is held constant for the whole following frame. Video passes
// through with exactly one clock of latency.
// Ports:
//   clk, rst_n                    : pixel clock, async active-low reset
//   per_frame_vsync/href/clken    : input frame, line and pixel strobes
//   per_img_Y                     : input dark-channel pixel
//   post_frame_vsync/href/clken   : strobes delayed one clock
//   post_img_Y                    : pixel delayed one clock
//   atmos_A                       : current atmospheric light estimate
//   atmos_valid                   : sticky, set by the first good frame
//   frame_err                     : one-clock pulse, frame had wrong pixel count
// ---------------------------------------------------------------------------
module vip_atmos_light_estimate
   import vip_dehaze_pkg::*;
#(
   parameter logic [10:0] IMG_HDISP    = 11'd1024,
   parameter logic [10:0] IMG_VDISP    = 11'd768,
   parameter logic [7:0]  A_MIN        = 8'd160,
   parameter logic [7:0]  A_INIT       = 8'd255,
   parameter int          SMOOTH_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             per_frame_vsync,
   input  logic             per_frame_href,
   input  logic             per_frame_clken,
   input  logic [PIX_W-1:0] per_img_Y,
   output logic             post_frame_vsync,
   output logic             post_frame_href,
   output logic             post_frame_clken,
   output logic [PIX_W-1:0] post_img_Y,
   output logic [PIX_W-1:0] atmos_A,
   output logic             atmos_valid,
   output logic             frame_err
);

   localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_HDISP) * CNT_W'(IMG_VDISP);

   state_t              r_state;
   logic                r_pending;
   logic [PIX_W-1:0]    r_frame_max;
   logic [CNT_W-1:0]    r_pix_cnt;
   logic [PIX_W-1:0]    r_atmos_A;
   logic                r_atmos_valid;
   logic                r_frame_err;
   logic                r_href;
   logic                r_clken;
   logic [PIX_W-1:0]    r_Y;

   logic                w_vsync_d;
   logic                w_rise;
   logic                w_fall;
   logic                w_pix_valid;
   logic [PIX_W-1:0]    w_cur;
   logic signed [8:0]   w_diff;
   logic signed [8:0]   w_step;
   logic signed [9:0]   w_sum;
   logic [PIX_W-1:0]    w_smoothed;

   vip_frame_sync_edge u_sync_edge (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_vsync   (per_frame_vsync),
      .o_vsync_d (w_vsync_d),
      .o_rise    (w_rise),
      .o_fall    (w_fall)
   );

   assign w_pix_valid = per_frame_vsync & per_frame_href & per_frame_clken;

   // Clamp the frame maximum, then move A a fraction of the way toward it.
   // The difference is kept signed so a falling maximum pulls A down.
   assign w_cur      = (r_frame_max > A_MIN) ? r_frame_max : A_MIN;
   assign w_diff     = $signed({1'b0, w_cur}) - $signed({1'b0, r_atmos_A});
   assign w_step     = w_diff >>> SMOOTH_SHIFT;
   assign w_sum      = $signed({2'b00, r_atmos_A}) + $signed({w_step[8], w_step});
   assign w_smoothed = sat8(w_sum);

   // Video pass-through; the delayed vsync comes from the edge detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_href  <= 1'b0;
         r_clken <= 1'b0;
         r_Y     <= '0;
      end else begin
         r_href  <= per_frame_href;
         r_clken <= per_frame_clken;
         r_Y     <= per_img_Y;
      end
   end

   // Frame capture FSM: track max and pixel count during the frame, then
   // spend one clock committing the new estimate. A frame start arriving
   // during that commit clock is remembered in r_pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pending     <= 1'b0;
         r_frame_max   <= '0;
         r_pix_cnt     <= '0;
         r_atmos_A     <= A_INIT;
         r_atmos_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_rise || r_pending) begin
                  r_state     <= ACTIVE;
                  r_pending   <= 1'b0;
                  r_frame_max <= '0;
                  r_pix_cnt   <= '0;
               end
            end
            ACTIVE: begin
               if (w_fall) begin
                  r_state <= UPDATE;
               end else if (w_pix_valid) begin
                  if (r_pix_cnt != '1) begin
                     r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                  end
                  if (per_img_Y > r_frame_max) begin
                     r_frame_max <= per_img_Y;
                  end
               end
            end
            UPDATE: begin
               r_state   <= IDLE;
               r_pending <= w_rise;
               if (r_pix_cnt != FRAME_PIX) begin
                  r_frame_err <= 1'b1;
               end else begin
                  r_atmos_A     <= r_atmos_valid ? w_smoothed : w_cur;
                  r_atmos_valid <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign post_frame_vsync = w_vsync_d;
   assign post_frame_href  = r_href;
   assign post_frame_clken = r_clken;
   assign post_img_Y       = r_Y;
   assign atmos_A          = r_atmos_A;
   assign atmos_valid      = r_atmos_valid;
   assign frame_err        = r_frame_err;

endmodule
